// File: rtl/isolde_vlen_batch_assembler_if.sv
// Handshake bundle between the IF stage, the batch assembler and the ISOLDE decoder.
// The slave modport is the assembler's view; master is the fetch/decode side.
interface isolde_vlen_batch_assembler_if;
  logic              fetch_valid_i;
  logic [31:0]       fetch_rdata_i;
  logic              fetch_ready_o;
  logic              batch_valid_o;
  logic [4:0][31:0]  batch_o;
  logic [2:0]        batch_len_o;
  logic              batch_illegal_o;
  logic              batch_ready_i;

  modport slave (
    input  fetch_valid_i,
    input  fetch_rdata_i,
    output fetch_ready_o,
    output batch_valid_o,
    output batch_o,
    output batch_len_o,
    output batch_illegal_o,
    input  batch_ready_i
  );

  modport master (
    output fetch_valid_i,
    output fetch_rdata_i,
    input  fetch_ready_o,
    input  batch_valid_o,
    input  batch_o,
    input  batch_len_o,
    input  batch_illegal_o,
    output batch_ready_i
  );
endinterface

// File: rtl/isolde_vlen_batch_assembler.sv
// Collects an ISOLDE variable-length instruction (head + up to 4 extension words)
// into a 5-slot batch and hands it to the decoder over valid/ready.
//
// state   | meaning
// IDLE    | waiting for a head word, fetch_ready high
// COLLECT | head latched, gathering extension words into slot[cnt]
// PRESENT | batch complete, batch_valid high, fetch stalled
module isolde_vlen_batch_assembler #(
  parameter logic [6:0] ISOLDE_OPCODE = 7'b1111011
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          busy_o,
  isolde_vlen_batch_assembler_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [4:0][31:0] batch_q, batch_d;
  logic [2:0]       len_q, len_d;
  logic             illegal_q, illegal_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             fetch_ready;
  logic             accept;
  logic [2:0]       nnn;
  logic [2:0]       head_len;
  logic             head_illegal;

  assign nnn = bus.fetch_rdata_i[14:12];

  // Length decode of the word currently offered; only used when it is a head.
  always_comb begin
    head_len     = 3'd1;
    head_illegal = 1'b0;
    if (bus.fetch_rdata_i[1:0] != 2'b11) begin
      head_illegal = 1'b1;
    end else if (bus.fetch_rdata_i[6:0] == ISOLDE_OPCODE) begin
      if (nnn <= 3'd4) begin
        head_len = nnn + 3'd1;
      end else begin
        head_illegal = 1'b1;
      end
    end
  end

  // Ready depends only on state and flush so the fetch side sees no comb loop.
  assign fetch_ready = ~flush_i & ((state_q == S_IDLE) | (state_q == S_COLLECT));
  assign accept      = bus.fetch_valid_i & fetch_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    batch_d   = batch_q;
    len_d     = len_q;
    illegal_d = illegal_q;

    if (flush_i) begin
      state_d   = S_IDLE;
      cnt_d     = 3'd0;
      batch_d   = '0;
      len_d     = 3'd0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            batch_d    = '0;
            batch_d[0] = bus.fetch_rdata_i;
            len_d      = head_len;
            illegal_d  = head_illegal;
            if (head_len == 3'd1) begin
              state_d = S_PRESENT;
            end else begin
              cnt_d   = 3'd1;
              state_d = S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            for (int i = 1; i < 5; i++) begin
              if (cnt_q == 3'(i)) batch_d[i] = bus.fetch_rdata_i;
            end
            // cnt parks at 0 after the last slot so it never runs past len-1
            if (cnt_q == len_q - 3'd1) begin
              cnt_d   = 3'd0;
              state_d = S_PRESENT;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_PRESENT: begin
          if (bus.batch_ready_i) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end

    valid_d = (state_d == S_PRESENT);
    busy_d  = (state_d == S_COLLECT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      batch_q   <= '0;
      len_q     <= 3'd0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      batch_q   <= batch_d;
      len_q     <= len_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.fetch_ready_o   = fetch_ready;
  assign bus.batch_valid_o   = valid_q;
  assign bus.batch_o         = batch_q;
  assign bus.batch_len_o     = len_q;
  assign bus.batch_illegal_o = illegal_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_isolde_vlen_batch_assembler.sv
// Directed bench for the ISOLDE batch assembler; inputs driven and outputs
// sampled on the falling edge, the DUT acts on the rising edge.
module tb_isolde_vlen_batch_assembler;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  isolde_vlen_batch_assembler_if bif ();

  isolde_vlen_batch_assembler dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bif.slave)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bif.fetch_valid_i = 1'b0; bif.fetch_rdata_i = '0; bif.batch_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bif.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bif.fetch_ready_o); end
    n_tests++;
    if ({bif.batch_valid_o, bif.batch_illegal_o, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got v=%b ill=%b busy=%b want 000", bif.batch_valid_o, bif.batch_illegal_o, busy);
    end
    n_tests++;
    if (bif.batch_o !== '0 || bif.batch_len_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_batch got len=%0d batch=%h want 0", bif.batch_len_o, bif.batch_o);
    end
  endtask

  task automatic test_single();
    logic [4:0][31:0] exp;
    exp = {32'h0, 32'h0, 32'h0, 32'h0, 32'h00A50533};
    bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = 32'h00A50533;
    #1;
    n_tests++;
    if (bif.fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", bif.fetch_ready_o); end
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd1 || bif.batch_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL single_out got v=%b len=%0d ill=%b want v=1 len=1 ill=0", bif.batch_valid_o, bif.batch_len_o, bif.batch_illegal_o);
    end
    n_tests++;
    if (bif.batch_o !== exp) begin n_fail++; $display("FAIL single_batch got %h want %h", bif.batch_o, exp); end
    n_tests++;
    if (bif.fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_present_ready got %b want 0", bif.fetch_ready_o); end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b0 || bif.fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL single_release got v=%b rdy=%b want v=0 rdy=1", bif.batch_valid_o, bif.fetch_ready_o);
    end
  endtask

  task automatic test_isolde5();
    logic [31:0]      seq [7];
    logic             vld [7];
    logic [4:0][31:0] exp;
    seq = '{32'h0000407B, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h33333333, 32'h44444444};
    vld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h0000407B};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        n_tests++;
        if (busy !== 1'b1 || bif.batch_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL isolde5_collect step %0d got busy=%b v=%b want busy=1 v=0", i, busy, bif.batch_valid_o);
        end
      end
      bif.fetch_valid_i = vld[i]; bif.fetch_rdata_i = seq[i];
      @(negedge clk);
    end
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || busy !== 1'b0 || bif.batch_len_o !== 3'd5 || bif.batch_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL isolde5_out got v=%b busy=%b len=%0d ill=%b want v=1 busy=0 len=5 ill=0", bif.batch_valid_o, busy, bif.batch_len_o, bif.batch_illegal_o);
    end
    n_tests++;
    if (bif.batch_o !== exp) begin n_fail++; $display("FAIL isolde5_batch got %h want %h", bif.batch_o, exp); end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
  endtask

  task automatic test_illegal_len();
    bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = 32'h0000707B;
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd1 || bif.batch_illegal_o !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_len got v=%b len=%0d ill=%b busy=%b want v=1 len=1 ill=1 busy=0", bif.batch_valid_o, bif.batch_len_o, bif.batch_illegal_o, busy);
    end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
    bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = 32'h00A50533;
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd1 || bif.batch_illegal_o !== 1'b0 || bif.batch_o[0] !== 32'h00A50533) begin
      n_fail++; $display("FAIL illegal_next_head got v=%b len=%0d ill=%b s0=%h want v=1 len=1 ill=0 s0=00a50533", bif.batch_valid_o, bif.batch_len_o, bif.batch_illegal_o, bif.batch_o[0]);
    end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [4:0][31:0] exp;
    logic [31:0]      words [3];
    exp   = {32'h0, 32'h0, 32'hBBBB0002, 32'hAAAA0001, 32'h0000207B};
    words = '{32'h0000207B, 32'hAAAA0001, 32'hBBBB0002};
    for (int i = 0; i < 3; i++) begin
      bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = words[i];
      @(negedge clk);
    end
    bif.fetch_rdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd3 || bif.batch_o !== exp || bif.fetch_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL backpressure_hold cyc %0d got v=%b len=%0d rdy=%b batch=%h want v=1 len=3 rdy=0 batch=%h", i, bif.batch_valid_o, bif.batch_len_o, bif.fetch_ready_o, bif.batch_o, exp);
      end
      @(negedge clk);
    end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b0 || bif.fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release got v=%b rdy=%b want v=0 rdy=1", bif.batch_valid_o, bif.fetch_ready_o);
    end
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_o[0] !== 32'hDEADBEEF || bif.batch_len_o !== 3'd1 || bif.batch_illegal_o !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_next got v=%b s0=%h len=%0d ill=%b want v=1 s0=deadbeef len=1 ill=0", bif.batch_valid_o, bif.batch_o[0], bif.batch_len_o, bif.batch_illegal_o);
    end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = 32'h0000307B;
    @(negedge clk);
    bif.fetch_rdata_i = 32'h00000001;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b want 1", busy); end
    flush = 1'b1; bif.fetch_rdata_i = 32'h00B00093;
    #1;
    n_tests++;
    if (bif.fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bif.fetch_ready_o); end
    @(negedge clk);
    flush = 1'b0; bif.fetch_rdata_i = 32'h00000013;
    n_tests++;
    if (busy !== 1'b0 || bif.batch_valid_o !== 1'b0 || bif.batch_len_o !== 3'd0 || bif.batch_o !== '0) begin
      n_fail++; $display("FAIL flush_clear got busy=%b v=%b len=%0d batch=%h want all 0", busy, bif.batch_valid_o, bif.batch_len_o, bif.batch_o);
    end
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd1 || bif.batch_o[0] !== 32'h00000013 || bif.batch_o[1] !== 32'h0) begin
      n_fail++; $display("FAIL flush_next_head got v=%b len=%0d s0=%h s1=%h want v=1 len=1 s0=00000013 s1=0", bif.batch_valid_o, bif.batch_len_o, bif.batch_o[0], bif.batch_o[1]);
    end
    bif.batch_ready_i = 1'b1;
    @(negedge clk);
    bif.batch_ready_i = 1'b0;
  endtask

  task automatic test_compressed_reset();
    bif.fetch_valid_i = 1'b1; bif.fetch_rdata_i = 32'h00004501;
    @(negedge clk);
    bif.fetch_valid_i = 1'b0;
    n_tests++;
    if (bif.batch_valid_o !== 1'b1 || bif.batch_len_o !== 3'd1 || bif.batch_illegal_o !== 1'b1) begin
      n_fail++; $display("FAIL compressed got v=%b len=%0d ill=%b want v=1 len=1 ill=1", bif.batch_valid_o, bif.batch_len_o, bif.batch_illegal_o);
    end
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    #1;
    n_tests++;
    if (bif.batch_valid_o !== 1'b0 || bif.batch_o !== '0 || bif.batch_len_o !== 3'd0 ||
        bif.batch_illegal_o !== 1'b0 || busy !== 1'b0 || bif.fetch_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_present got v=%b len=%0d ill=%b busy=%b rdy=%b batch=%h want v=0 len=0 ill=0 busy=0 rdy=1 batch=0",
                         bif.batch_valid_o, bif.batch_len_o, bif.batch_illegal_o, busy, bif.fetch_ready_o, bif.batch_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_isolde5();
    test_illegal_len();
    test_backpressure();
    test_flush();
    test_compressed_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/isolde_vlen_batch_assembler.md
# isolde_vlen_batch_assembler

Fetch-side assembler for ISOLDE variable-length instructions. It accepts a stream of 32-bit instruction words from the fetch stage and determines the instruction length from the head word. It collects the head word plus any extension words into a 5-slot batch and presents the batch to the ISOLDE decoder over a valid/ready handshake. It is the producer of the instruction batch the ISOLDE decoder consumes, and sits between the IF stage and the ISOLDE decode stage.

## Interface
- `ISOLDE_OPCODE`, default 7'b1111011: major opcode (word[6:0]) that marks a variable-length ISOLDE head word.
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `fetch_valid_i` in 1: `fetch_rdata_i` holds a valid instruction word.
- `fetch_rdata_i` in 32: instruction word, in program order.
- `fetch_ready_o` out 1: the block accepts the word this cycle.
- `flush_i` in 1: abort the partial or presented batch (branch, exception, `~instr_exec`).
- `batch_valid_o` out 1: the batch outputs are valid.
- `batch_o` out [4:0][31:0]: slot 0 is the head word, slots 1..len-1 are extension words in fetch order, and unused slots are 0.
- `batch_len_o` out 3: number of words in the batch, 1..5.
- `batch_illegal_o` out 1: the head word is not decodable by length.
- `batch_ready_i` in 1: the decoder consumes the batch.
- `busy_o` out 1: a batch is partially collected (COLLECT state).

## Operation
- A word is accepted when `fetch_valid_i & fetch_ready_o`.
- Length decode on the head word `w`:
  - `w[1:0] != 2'b11` (compressed): len = 1, illegal = 1.
  - `w[6:0] == ISOLDE_OPCODE`: nnn = `w[14:12]`. If nnn ≤ 4, len = nnn + 1. If nnn ≥ 5, len = 1 and illegal = 1.
  - Any other opcode: len = 1, illegal = 0.
- FSM states and transitions:
  - IDLE: `fetch_ready_o` = 1.
    - On accept, the word is written to slot 0, slots 1..4 are cleared, and len/illegal are latched.
    - If len = 1, go to PRESENT. Otherwise `cnt` = 1 and go to COLLECT.
  - COLLECT: `fetch_ready_o` = 1, `busy_o` = 1.
    - On accept, the word is written to slot[`cnt`] and `cnt` increments.
    - When the accepted word is slot len-1, go to PRESENT.
    - No accept: stay, holding all contents.
  - PRESENT: `batch_valid_o` = 1 and `fetch_ready_o` = 0.
    - Batch outputs are stable while waiting.
    - On `batch_ready_i`, go to IDLE.
- `cnt` is 3 bits and never exceeds len-1 (max 4). Slot writes are indexed by `cnt` only.
- `flush_i` has highest priority in every state:
  - Next state is IDLE, `cnt` = 0, `batch_o` = 0, len = 0, illegal = 0.
  - A word offered in the same cycle is not accepted: `fetch_ready_o` = 0 while `flush_i` = 1.
  - A batch presented in the flush cycle is discarded even if `batch_ready_i` = 1. The consumer must ignore `batch_valid_o` when `flush_i` is high.
- Reset has the same effect as flush, and it overrides flush.

## Timing
- Reset values: `fetch_ready_o` = 1 (IDLE, `flush_i` low). `batch_valid_o` = 0, `batch_o` = 0, `batch_len_o` = 0, `batch_illegal_o` = 0, `busy_o` = 0.
- `fetch_ready_o` is combinational from state and `flush_i` only. It never depends on `fetch_valid_i`.
- `batch_valid_o`, `batch_o`, `batch_len_o`, `batch_illegal_o` and `busy_o` are registered.
- Latency: `batch_valid_o` rises the cycle after the final word is accepted.
  - A 1-word batch accepted at cycle t is valid at t+1.
  - An N-word batch with no fetch bubbles, head accepted at t, is valid at t+N.
- Throughput: the block does not accept a word in PRESENT, so back-to-back 1-word instructions take 2 cycles each. The handshake cycle is PRESENT→IDLE, and the next word is accepted from IDLE.
- Fetch bubbles in COLLECT extend latency one cycle each. There is no timeout.

## Test plan
- Single standard instruction: 0x00A50533 (add) offered at cycle 1 → accepted at cycle 1. At cycle 2: `batch_valid_o` = 1, len = 1, illegal = 0, slot0 = 0x00A50533, slots 1..4 = 0. It is released on `batch_ready_i`.
- 5-word ISOLDE instruction: head 0x0000407B (nnn = 4), then 0x11111111, 0x22222222, 0x33333333, 0x44444444, with a 2-cycle fetch bubble after word 2 → `busy_o` high throughout collection, valid one cycle after the last accept, len = 5, slots match in order.
- Illegal length: head 0x0000707B (nnn = 7) → 1-word batch, `batch_illegal_o` = 1, len = 1. The next word offered is treated as a new head.
- Backpressure: 3-word batch presented with `batch_ready_i` low for 4 cycles → outputs stable, `fetch_ready_o` = 0. `fetch_valid_i` held high with 0xDEADBEEF is not consumed until after release.
- Flush mid-collect: `flush_i` asserted after 2 of 4 words → `busy_o` falls next cycle and no batch is presented. The word offered during the flush cycle is not accepted, and the next word is decoded as a head.
- Compressed head 0x00004501 → illegal = 1, len = 1. Synchronous `rst_i` pulsed while in PRESENT → all outputs return to reset values the next cycle.
